// File: rtl/rocketcpu_audio_param_scheduler.sv
// Wishbone-mapped shadow registers for audio parameters; the shadow set is committed
// atomically to the active outputs on the next sample tick after a commit request.
module rocketcpu_audio_param_scheduler #(
    parameter logic [31:0] BASE_ADR = 32'h1000_0000,
    parameter int unsigned NPARAM   = 10
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    input  logic        i_sample_tick,
    input  logic [31:0] iparam_1,
    output logic [31:0] param_1,
    output logic [31:0] param_2,
    output logic [31:0] param_3,
    output logic [31:0] param_4,
    output logic [31:0] param_5,
    output logic [31:0] param_6,
    output logic [31:0] param_7,
    output logic [31:0] param_8,
    output logic [31:0] param_9,
    output logic [31:0] param_10,
    output logic        o_params_updated
);

    typedef enum logic [1:0] {StIdle, StArmed, StCopy} state_e;

    state_e      state_q, state_d;
    logic [31:0] shadow_q [10];
    logic [31:0] param_q  [10];
    logic        auto_q;
    logic        dirty_q;
    logic [7:0]  count_q;
    logic        updated_q;

    logic        accept;
    logic [31:0] offset;
    logic [29:0] word;
    logic        aligned;
    logic        shadow_hit;
    logic        shadow_wr;
    logic        ctrl_wr;
    logic        commit_req;
    logic [31:0] rd_data;

    assign accept     = i_wb_cyc & ~o_wb_ack;
    assign offset     = i_wb_adr - BASE_ADR;
    assign word       = offset[31:2];
    // Misaligned accesses are treated as unmapped.
    assign aligned    = (offset[1:0] == 2'b00);
    assign shadow_hit = aligned & (word < 30'(NPARAM));
    assign shadow_wr  = accept & i_wb_we & shadow_hit;
    assign ctrl_wr    = accept & i_wb_we & aligned & (word == 30'd10) & i_wb_sel[0];
    assign commit_req = ctrl_wr & i_wb_dat[0];

    always_comb begin
        rd_data = '0;
        if (shadow_hit) begin
            rd_data = shadow_q[word[3:0]];
        end else if (aligned && word == 30'd10) begin
            rd_data = {30'd0, auto_q, 1'b0};
        end else if (aligned && word == 30'd11) begin
            rd_data = {16'd0, count_q, 6'd0, dirty_q, state_q == StArmed};
        end else if (aligned && word == 30'd12) begin
            rd_data = iparam_1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (commit_req || (shadow_wr && auto_q)) state_d = StArmed;
            end
            StArmed: begin
                if (i_sample_tick) state_d = StCopy;
            end
            StCopy: begin
                // A shadow write landing on the copy edge missed this commit; re-arm for it.
                state_d = (shadow_wr && auto_q) ? StArmed : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q   <= StIdle;
            auto_q    <= 1'b0;
            dirty_q   <= 1'b0;
            count_q   <= 8'd0;
            updated_q <= 1'b0;
            o_wb_ack  <= 1'b0;
            o_wb_rdt  <= 32'd0;
            for (int i = 0; i < 10; i++) begin
                shadow_q[i] <= 32'd0;
                param_q[i]  <= 32'd0;
            end
        end else begin
            state_q   <= state_d;
            o_wb_ack  <= accept;
            updated_q <= (state_q == StCopy);
            if (accept) o_wb_rdt <= rd_data;
            if (ctrl_wr) auto_q <= i_wb_dat[1];
            if (state_q == StCopy) begin
                for (int i = 0; i < 10; i++) param_q[i] <= shadow_q[i];
                count_q <= count_q + 8'd1;
            end
            if (shadow_wr) begin
                dirty_q <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (i_wb_sel[b]) shadow_q[word[3:0]][8*b +: 8] <= i_wb_dat[8*b +: 8];
                end
            end else if (state_q == StCopy) begin
                dirty_q <= 1'b0;
            end
        end
    end

    assign param_1          = param_q[0];
    assign param_2          = param_q[1];
    assign param_3          = param_q[2];
    assign param_4          = param_q[3];
    assign param_5          = param_q[4];
    assign param_6          = param_q[5];
    assign param_7          = param_q[6];
    assign param_8          = param_q[7];
    assign param_9          = param_q[8];
    assign param_10         = param_q[9];
    assign o_params_updated = updated_q;

endmodule

// File: doc/rocketcpu_audio_param_scheduler.md
ROCKETCPU_AUDIO_PARAM_SCHEDULER -- requirements
Module: rocketcpu_audio_param_scheduler

Interface
REQ-001 SHALL have parameter BASE_ADR, default 32'h1000_0000, bus address of shadow register 0.
REQ-002 SHALL have parameter NPARAM, default 10, number of audio parameters, fixed range 1..10.
REQ-003 SHALL have i_wb_clk  input  1: single system clock, all logic on its rising edge.
REQ-004 SHALL have i_wb_rst_n  input  1: reset, asynchronous and active-low.
REQ-005 SHALL have i_wb_adr  input  32: byte address.
REQ-006 SHALL have i_wb_dat  input  32: write data.
REQ-007 SHALL have i_wb_sel  input  4: byte-lane enables for writes.
REQ-008 SHALL have i_wb_we  input  1: write enable.
REQ-009 SHALL have i_wb_cyc  input  1: cycle request; no separate stb.
REQ-010 SHALL have o_wb_rdt  output  32: registered read data.
REQ-011 SHALL have o_wb_ack  output  1: single-cycle acknowledge.
REQ-012 SHALL have i_sample_tick  input  1: one-cycle strobe per audio sample.
REQ-013 SHALL have iparam_1  input  32: status word from audio datapath, read-only.
REQ-014 SHALL have param_1 .. param_10  output  32 each: active parameters to audio datapath.
REQ-015 SHALL have o_params_updated  output  1: one-cycle pulse when active parameters change.

Function
REQ-016 Register map (offset from BASE_ADR) SHALL be: 0x00..0x24 shadow[0..9] RW; 0x28 CTRL RW; 0x2C STATUS RO; 0x30 iparam_1 RO; other addresses read 0, writes ignored.
REQ-017 CTRL SHALL be: bit0 COMMIT (write 1 requests commit, self-clears, reads 0); bit1 AUTO (RW, commit on any shadow write); other bits read 0.
REQ-018 STATUS SHALL be: bit0 PENDING (state ARMED), bit1 DIRTY (shadow differs-by-write since last commit), bits[15:8] commit counter, others 0.
REQ-019 o_wb_ack SHALL assert exactly one cycle, on the edge after i_wb_cyc is sampled high with o_wb_ack low; back-to-back cyc gives ack every second cycle.
REQ-020 Writes and o_wb_rdt capture SHALL occur only on the accept edge (i_wb_cyc high, o_wb_ack low); o_wb_rdt holds otherwise.
REQ-021 Shadow writes SHALL honour i_wb_sel per byte lane; CTRL write effective only when i_wb_sel[0]=1.
REQ-022 Shadow index >= NPARAM SHALL read 0 and ignore writes.
REQ-023 FSM states: IDLE, ARMED, COPY.
REQ-024 IDLE -> ARMED on COMMIT write, or on shadow write with AUTO=1.
REQ-025 ARMED -> COPY on the first i_sample_tick sampled high in a cycle after entering ARMED; a tick coincident with the arming write is ignored.
REQ-026 COPY (one cycle): param_n <= shadow[n-1] for all n, o_params_updated=1 next cycle, counter += 1 mod 256 (255 -> 0), DIRTY cleared; next state IDLE.
REQ-027 Shadow write accepted on the same edge as the COPY transfer SHALL NOT be included; DIRTY set; if AUTO=1 next state ARMED instead of IDLE.
REQ-028 Shadow writes in ARMED SHALL be included in the pending commit; COMMIT write in ARMED/COPY SHALL be absorbed (no second commit unless REQ-027 applies).
REQ-029 param outputs SHALL change only in COPY; never mid-sample.

Reset
REQ-030 Asserting i_wb_rst_n low SHALL immediately force: FSM IDLE, all shadow and param outputs 0, CTRL 0, counter 0, DIRTY 0, o_wb_ack 0, o_wb_rdt 0, o_params_updated 0.
REQ-031 Reset mid-ARMED SHALL discard the pending commit; first post-reset tick causes no update.

Verification
REQ-032 Write 0x1234_5678 to 0x1000_0004, COMMIT, tick -> param_2=0x1234_5678 one cycle after COPY, o_params_updated one pulse, STATUS[15:8]=1.
REQ-033 Write shadow[0]=0xAABB_CCDD with sel=4'b0011 over 0xFFFF_FFFF -> readback 0xFFFF_CCDD; param_1 unchanged until commit.
REQ-034 AUTO=1, shadow[3] write coincident with COPY edge -> committed value excludes it, DIRTY=1, FSM re-ARMED, next tick applies it.
REQ-035 256 commits -> STATUS[15:8] wraps to 0x00; read 0x1000_0040 -> 0; read 0x1000_0030 -> iparam_1.
REQ-036 Reset asserted while ARMED -> all outputs 0 asynchronously; subsequent ticks leave params 0 and no o_params_updated.
